fetch: RTL and testbench

Instruction fetch stage feeding the execute stage. It owns the fetch PC and issues single-outstanding word reads to instruction memory. Fetched instructions are buffered in a small FIFO and handed to execute with a taken/not-taken prediction. The block consumes execute's flush and redirect outputs (`o_flush`, `o_exec_pc`, `o_pc_update`) to recover from mispredictions and to train a direct-mapped branch target buffer (BTB).

---
 rtl/fetch.sv | 97 +++++++++
 tb/tb_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// fetch: instruction fetch stage with a single outstanding memory read, a 2-entry
// instruction buffer and a direct-mapped BTB trained from execute's flush redirects.
module fetch #(
   parameter int RW = 16,
   parameter int IW = 32,
   parameter int BTB_LOG = 3,
   parameter logic [RW-1:0] RESET_PC = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   output logic          o_mem_req,
   output logic [RW-1:0] o_mem_addr,
   input  logic          i_mem_ack,
   input  logic [IW-1:0] i_mem_data,
   output logic          o_submit,
   input  logic          i_ready,
   output logic [IW-1:0] o_instr,
   output logic [RW-1:0] o_pc,
   output logic          o_jmp_predict,
   input  logic          i_flush,
   input  logic          i_pc_update,
   input  logic [RW-1:0] i_exec_pc
);
   localparam int N = 1 << BTB_LOG;
   localparam int TW = RW - BTB_LOG;

   logic [RW-1:0] fpc, req_addr, last_pc;
   logic busy, drop, req_pred;
   logic [IW-1:0] f_instr [2];
   logic [RW-1:0] f_pc [2];
   logic [1:0] f_pred;
   logic rd, wr;
   logic [1:0] cnt;
   logic [N-1:0] btb_v;
   logic [TW-1:0] btb_tag [N];
   logic [RW-1:0] btb_tgt [N];
   logic [BTB_LOG-1:0] idx, li;
   logic hit, issue, push, pop, nonempty;

   always_comb begin
      idx = fpc[BTB_LOG-1:0];
      li = last_pc[BTB_LOG-1:0];
      hit = btb_v[idx] && btb_tag[idx] == fpc[RW-1:BTB_LOG];
      nonempty = cnt != 2'd0;
      issue = i_rst & ~busy & (cnt < 2'd2) & ~i_flush;
      // acks arriving with nothing outstanding (e.g. after reset) are ignored
      push = busy & i_mem_ack & ~drop & ~i_flush;
      o_submit = nonempty & ~i_flush;
      pop = o_submit & i_ready;
      o_mem_req = busy | issue;
      o_mem_addr = busy ? req_addr : fpc;
      o_instr = nonempty ? f_instr[rd] : '0;
      o_pc = nonempty ? f_pc[rd] : '0;
      o_jmp_predict = nonempty & f_pred[rd];
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         fpc <= RESET_PC;
         req_addr <= RESET_PC;
         req_pred <= 1'b0;
         busy <= 1'b0;
         drop <= 1'b0;
         cnt <= 2'd0;
         rd <= 1'b0;
         wr <= 1'b0;
         last_pc <= '0;
         btb_v <= '0;
      end else begin
         busy <= issue | (busy & ~i_mem_ack);
         drop <= busy & ~i_mem_ack & (drop | i_flush);
         if (issue) begin
            req_addr <= fpc;
            req_pred <= hit;
         end
         fpc <= i_flush ? i_exec_pc : issue ? (hit ? btb_tgt[idx] : fpc + 1'b1) : fpc;
         wr <= i_flush ? 1'b0 : wr ^ push;
         rd <= i_flush ? 1'b0 : rd ^ pop;
         cnt <= i_flush ? 2'd0 : cnt + 2'(push) - 2'(pop);
         if (pop & i_pc_update) last_pc <= o_pc;
         // a redirect to last_pc+1 means the taken prediction was wrong
         if (i_flush) btb_v[li] <= i_exec_pc != last_pc + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         f_instr[wr] <= i_mem_data;
         f_pc[wr] <= req_addr;
         f_pred[wr] <= req_pred;
      end
      if (i_rst & i_flush) begin
         btb_tag[li] <= last_pc[RW-1:BTB_LOG];
         btb_tgt[li] <= i_exec_pc;
      end
   end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed stimulus against fetch with a stream-level model of the
// expected instruction sequence (program order + BTB predictions) and a memory responder.
module tb_fetch;
   localparam int RW = 16;
   localparam int IW = 32;

   logic i_clk = 0, i_rst = 0, i_mem_ack = 0, i_ready = 0, i_flush = 0, i_pc_update = 0;
   logic o_mem_req, o_submit, o_jmp_predict;
   logic [RW-1:0] o_mem_addr, o_pc, i_exec_pc = '0;
   logic [IW-1:0] o_instr, i_mem_data = '0;

   always #5 i_clk = ~i_clk;

   fetch #(.RW(RW), .IW(IW), .BTB_LOG(3), .RESET_PC(16'h0)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
      .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data), .o_submit(o_submit), .i_ready(i_ready),
      .o_instr(o_instr), .o_pc(o_pc), .o_jmp_predict(o_jmp_predict), .i_flush(i_flush),
      .i_pc_update(i_pc_update), .i_exec_pc(i_exec_pc)
   );

   int n_tests = 0, n_fail = 0;
   bit started = 0;
   // memory responder
   bit r_pend = 0, r_stale = 0;
   logic [RW-1:0] r_addr = '0;
   int r_wait = 0, lat = 0;
   logic [RW-1:0] req_log [$];
   // stream model: next expected PC, last accepted PC, BTB keyed by index holding full PC
   logic [RW-1:0] m_pc = '0, m_last = '0;
   bit m_v [8];
   logic [RW-1:0] m_bpc [8], m_btgt [8];
   logic [63:0] x_log [$];
   bit h;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit m_hit(input logic [RW-1:0] pc);
      return m_v[pc[2:0]] && m_bpc[pc[2:0]] == pc;
   endfunction

   always @(posedge i_clk) begin
      #1;
      i_mem_ack = 0;
      if (r_pend) begin
         if (r_wait == 0) begin
            i_mem_ack = 1;
            i_mem_data = {16'h0, r_addr};
         end else r_wait--;
      end
   end

   always @(negedge i_clk) begin
      if (started && !i_rst) begin
         m_pc = '0;
         m_last = '0;
         for (int i = 0; i < 8; i++) m_v[i] = 0;
         if (r_pend) r_stale = 1;
      end else if (started) begin
         if (i_flush) begin
            chk("submit_in_flush", 64'(o_submit), 64'(0));
            chk("no_issue_in_flush", 64'(o_mem_req && !r_pend), 64'(0));
            if (i_exec_pc == m_last + 1'b1) m_v[m_last[2:0]] = 0;
            else begin
               m_v[m_last[2:0]] = 1;
               m_bpc[m_last[2:0]] = m_last;
               m_btgt[m_last[2:0]] = i_exec_pc;
            end
            m_pc = i_exec_pc;
         end else if (o_submit && i_ready) begin
            h = m_hit(m_pc);
            chk("xfer_pc", 64'(o_pc), 64'(m_pc));
            chk("xfer_instr", 64'(o_instr), 64'(m_pc));
            chk("xfer_predict", 64'(o_jmp_predict), 64'(h));
            x_log.push_back({15'b0, o_jmp_predict, o_instr, o_pc});
            if (i_pc_update) m_last = m_pc;
            m_pc = h ? m_btgt[m_pc[2:0]] : m_pc + 1'b1;
         end
         if (r_pend && !r_stale && o_mem_req) chk("addr_stable", 64'(o_mem_addr), 64'(r_addr));
      end
      if (i_mem_ack) begin
         r_pend = 0;
         r_stale = 0;
      end else if (o_mem_req === 1'b1 && !r_pend) begin
         r_pend = 1;
         r_addr = o_mem_addr;
         r_wait = lat;
         req_log.push_back(o_mem_addr);
      end
   end

   task automatic tick;
      @(posedge i_clk);
      #2;
   endtask

   task automatic wait_log(input int n, input string nm);
      for (int k = 0; k < 300 && x_log.size() < n; k++) tick;
      chk(nm, 64'(x_log.size() >= n), 64'(1));
   endtask

   task automatic wait_req(input string nm);
      for (int k = 0; k < 300 && req_log.size() < 1; k++) tick;
      chk(nm, 64'(req_log.size() >= 1), 64'(1));
   endtask

   task automatic flush_now(input logic [RW-1:0] v);
      i_flush = 1;
      i_exec_pc = v;
      req_log.delete();
      x_log.delete();
      tick;
      i_flush = 0;
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_req"}, 64'(o_mem_req), 64'(0));
      chk({nm, "_submit"}, 64'(o_submit), 64'(0));
      chk({nm, "_pred"}, 64'(o_jmp_predict), 64'(0));
      chk({nm, "_instr"}, 64'(o_instr), 64'(0));
      chk({nm, "_pc"}, 64'(o_pc), 64'(0));
      chk({nm, "_addr"}, 64'(o_mem_addr), 64'(0));
   endtask

   initial begin
      int k;
      repeat (2) tick;
      started = 1;
      tick;
      #2 chk_reset_outputs("reset");
      // in-order stream from RESET_PC, 1-cycle ack
      tick;
      i_rst = 1;
      i_ready = 1;
      i_pc_update = 1;
      #2 chk("first_req", 64'({o_mem_req, o_mem_addr}), 64'({1'b1, 16'h0}));
      k = 0;
      do begin
         tick;
         #2 k++;
      end while (!o_submit && k < 10);
      chk("submit_latency", 64'(k), 64'(2));
      wait_log(4, "stream_timeout");
      for (int i = 0; i < 4; i++) chk("stream_lit", x_log[i], {16'b0, 32'(i), 16'(i)});
      // back-pressure: buffer fills to two, fetch stalls
      i_ready = 0;
      i_pc_update = 0;
      repeat (10) tick;
      #2 chk("hold_req", 64'(o_mem_req), 64'(0));
      chk("hold_submit", 64'(o_submit), 64'(1));
      tick;
      i_ready = 1;
      i_pc_update = 1;
      #2 chk("rel0", 64'(o_submit), 64'(1));
      tick;
      #2 chk("rel1", 64'(o_submit), 64'(1));
      tick;
      #2 chk("rel2", 64'(o_submit), 64'(0));
      // flush with a request to 0x05 outstanding, ack 3 cycles after the flush
      lat = 3;
      tick;
      flush_now(16'h05);
      wait_req("req5_timeout");
      chk("req5_addr", 64'(req_log[0]), 64'(16'h05));
      flush_now(16'h40);
      wait_log(1, "after40_timeout");
      chk("after40_lit", x_log[0], {16'b0, 32'h40, 16'h40});
      // BTB training, hit, and invalidation
      lat = 0;
      tick;
      flush_now(16'h10);
      wait_log(1, "b10_timeout");
      chk("b10_pc", 64'(x_log[0][15:0]), 64'(16'h10));
      flush_now(16'h30);
      wait_log(2, "b31_timeout");
      chk("b31_pc", 64'(x_log[1][15:0]), 64'(16'h31));
      flush_now(16'h10);
      wait_log(1, "bhit_timeout");
      chk("bhit_lit", x_log[0], {15'b0, 1'b1, 32'h10, 16'h10});
      chk("bhit_next_addr", 64'(req_log[1]), 64'(16'h30));
      flush_now(16'h11);
      wait_log(1, "b11_timeout");
      chk("b11_pc", 64'(x_log[0][15:0]), 64'(16'h11));
      flush_now(16'h10);
      wait_log(1, "bclr_timeout");
      chk("bclr_lit", x_log[0], {16'b0, 32'h10, 16'h10});
      chk("bclr_next_addr", 64'(req_log[1]), 64'(16'h11));
      // flush coinciding with ack
      lat = 1;
      k = 0;
      do begin
         tick;
         k++;
      end while (!i_mem_ack && k < 50);
      chk("ack_seen", 64'(i_mem_ack), 64'(1));
      flush_now(16'h50);
      #2 chk("fa_req", 64'({o_mem_req, o_mem_addr}), 64'({1'b1, 16'h50}));
      wait_log(1, "fa_timeout");
      chk("fa_lit", x_log[0], {16'b0, 32'h50, 16'h50});
      // reset during an outstanding request; its ack lands after reset
      lat = 2;
      tick;
      req_log.delete();
      wait_req("rr_timeout");
      i_rst = 0;
      tick;
      #2 chk_reset_outputs("midreset");
      tick;
      i_rst = 1;
      x_log.delete();
      #2 chk("late_ack_present", 64'(i_mem_ack), 64'(1));
      chk("rr_submit0", 64'(o_submit), 64'(0));
      tick;
      #2 chk("rr_submit1", 64'(o_submit), 64'(0));
      wait_log(1, "rr_timeout2");
      chk("rr_first_lit", x_log[0], 64'(0));
      repeat (4) tick;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
